// File: rtl/dispatch_unit.sv
// -----------------------------------------------------------------------------
// dispatch_unit
//   Single-entry dispatch buffer between rename and the ALU / branch / LSU
//   reservation stations. Tracks a per-physical-register busy table so every
//   dispatched entry carries true operand-ready flags, including wakeups from
//   writebacks that happen in the same cycle.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_instr/in_fu_sel rename-side request (fu: 0 ALU, 1 BR, 2 LSU, 3 ALU)
//   in_ready                   buffer can accept this cycle
//   alu/br/lsu_full            station full flags
//   alu/br/lsu_dispatch_en     one-hot write strobe to the selected station
//   out_instr                  buffered instruction (shared by all stations)
//   out_prs1/2_ready           operand readiness for out_instr
//   wb_en_*/wb_prd_*           writeback wakeups (ALU, branch, LSU)
//   flush                      synchronous squash of buffer and busy table
//   stall_cycles               saturating count of blocked buffer cycles
// -----------------------------------------------------------------------------
package dispatch_pkg;
    localparam int PHYS_REG_BITS = 6;

    typedef struct packed {
        logic [15:0]              uop;
        logic                     reg_write;
        logic [PHYS_REG_BITS-1:0] prd;
        logic [PHYS_REG_BITS-1:0] prs1;
        logic [PHYS_REG_BITS-1:0] prs2;
    } renamed_instr_t;
endpackage

module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int NUM_PREGS = 2**PHYS_REG_BITS,
    parameter int CNT_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  renamed_instr_t           in_instr,
    input  logic [1:0]               in_fu_sel,
    output logic                     in_ready,
    input  logic                     alu_full,
    input  logic                     br_full,
    input  logic                     lsu_full,
    output logic                     alu_dispatch_en,
    output logic                     br_dispatch_en,
    output logic                     lsu_dispatch_en,
    output renamed_instr_t           out_instr,
    output logic                     out_prs1_ready,
    output logic                     out_prs2_ready,
    input  logic                     wb_en_alu,
    input  logic                     wb_en_branch,
    input  logic                     wb_en_lsu,
    input  logic [PHYS_REG_BITS-1:0] wb_prd_alu,
    input  logic [PHYS_REG_BITS-1:0] wb_prd_branch,
    input  logic [PHYS_REG_BITS-1:0] wb_prd_lsu,
    input  logic                     flush,
    output logic [CNT_W-1:0]         stall_cycles
);

    localparam logic [1:0] FU_BR  = 2'd1;
    localparam logic [1:0] FU_LSU = 2'd2;

    logic                 buf_valid_q, buf_valid_d;
    renamed_instr_t       buf_instr_q, buf_instr_d;
    logic [1:0]           buf_fu_q, buf_fu_d;
    logic [NUM_PREGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]     stall_q, stall_d;

    logic                 sel_full_s;
    logic                 fire_s;
    logic                 dispatch_ok_s;
    logic                 accept_s;
    logic [2:0]           wb_hit1_s;
    logic [2:0]           wb_hit2_s;

    // An operand is ready if it is p0, not busy, or woken by a writeback now.
    function automatic logic operand_ready(input logic [PHYS_REG_BITS-1:0] prs,
                                           input logic                     busy_bit,
                                           input logic [2:0]               wb_hit);
        return (prs == {PHYS_REG_BITS{1'b0}}) || !busy_bit || (|wb_hit);
    endfunction

    // Handshake, routing and readiness: all combinational from buffer state.
    always_comb begin
        case (buf_fu_q)
            FU_BR:   sel_full_s = br_full;
            FU_LSU:  sel_full_s = lsu_full;
            default: sel_full_s = alu_full;   // 0 and reserved 3 go to ALU
        endcase

        fire_s        = buf_valid_q && !sel_full_s;
        // fire still frees the buffer slot logically, but flush squashes the strobe.
        dispatch_ok_s = fire_s && !flush;
        in_ready      = (!buf_valid_q || fire_s) && !flush;
        accept_s      = in_valid && in_ready;

        alu_dispatch_en = 1'b0;
        br_dispatch_en  = 1'b0;
        lsu_dispatch_en = 1'b0;
        if (dispatch_ok_s) begin
            case (buf_fu_q)
                FU_BR:   br_dispatch_en  = 1'b1;
                FU_LSU:  lsu_dispatch_en = 1'b1;
                default: alu_dispatch_en = 1'b1;
            endcase
        end else begin
            alu_dispatch_en = 1'b0;
        end

        wb_hit1_s = {wb_en_lsu    && (wb_prd_lsu    == buf_instr_q.prs1),
                     wb_en_branch && (wb_prd_branch == buf_instr_q.prs1),
                     wb_en_alu    && (wb_prd_alu    == buf_instr_q.prs1)};
        wb_hit2_s = {wb_en_lsu    && (wb_prd_lsu    == buf_instr_q.prs2),
                     wb_en_branch && (wb_prd_branch == buf_instr_q.prs2),
                     wb_en_alu    && (wb_prd_alu    == buf_instr_q.prs2)};

        out_prs1_ready = operand_ready(buf_instr_q.prs1, busy_q[buf_instr_q.prs1], wb_hit1_s);
        out_prs2_ready = operand_ready(buf_instr_q.prs2, busy_q[buf_instr_q.prs2], wb_hit2_s);
        out_instr      = buf_instr_q;
        stall_cycles   = stall_q;
    end

    // Next-state for buffer, busy table and stall counter.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_fu_d    = buf_fu_q;
        busy_d      = busy_q;
        stall_d     = stall_q;

        if (flush) begin
            buf_valid_d = 1'b0;
            busy_d      = {NUM_PREGS{1'b0}};
        end else begin
            if (accept_s) begin
                buf_valid_d = 1'b1;
                buf_instr_d = in_instr;
                buf_fu_d    = in_fu_sel;
            end else if (fire_s) begin
                buf_valid_d = 1'b0;
            end else begin
                buf_valid_d = buf_valid_q;
            end

            // Clears first so that a same-cycle set on the same register wins.
            if (wb_en_alu)    busy_d[wb_prd_alu]    = 1'b0;
            else              busy_d                = busy_d;
            if (wb_en_branch) busy_d[wb_prd_branch] = 1'b0;
            else              busy_d                = busy_d;
            if (wb_en_lsu)    busy_d[wb_prd_lsu]    = 1'b0;
            else              busy_d                = busy_d;
            if (fire_s && buf_instr_q.reg_write)
                busy_d[buf_instr_q.prd] = 1'b1;
            else
                busy_d = busy_d;

            if (buf_valid_q && !fire_s && (stall_q != {CNT_W{1'b1}}))
                stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
            else
                stall_d = stall_q;
        end
        busy_d[0] = 1'b0;   // p0 is hardwired ready
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_fu_q    <= 2'd0;
            busy_q      <= {NUM_PREGS{1'b0}};
            stall_q     <= {CNT_W{1'b0}};
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_fu_q    <= buf_fu_d;
            busy_q      <= busy_d;
            stall_q     <= stall_d;
        end
    end

endmodule
